hatch_imem_arbiter: RTL
=======================

// Module: hatch_imem_arbiter
// PURPOSE
//  Owns the single-port 48-bit instruction memory (6-byte insns, byte-addressed by CPU).
//  Arbitrates CPU fetch port vs program-loader write port; converts byte address to word
//  index (addr/6) in a registered decode stage; flags misaligned/out-of-range fetches.
//  Sits between cpu and the instruction RAM inside top.
// PARAMETERS
//  DEPTH  256  instruction words in memory
//  AW     8    index width, clog2(DEPTH)
//  DW     48   instruction width
// PORTS
//  clk          in   1      system clock
//  rst          in   1      synchronous reset, active-high
//  fetch_req    in   1      CPU fetch request; held high until fetch_gnt
//  fetch_addr   in   32     byte address, sampled in grant cycle
//  fetch_gnt    out  1      1-cycle pulse: fetch accepted
//  fetch_valid  out  1      1-cycle pulse: response present
//  fetch_data   out  DW     instruction (0 on fault)
//  fetch_fault  out  1      qualified by fetch_valid: misaligned or out of range
//  load_req     in   1      loader write request; held high until load_gnt
//  load_index   in   AW     word index to write, sampled in grant cycle
//  load_data    in   DW     word to write, sampled in grant cycle
//  load_gnt     out  1      1-cycle pulse: write accepted
//  mem_en       out  1      RAM enable
//  mem_we       out  1      RAM write enable (only with mem_en)
//  mem_index    out  AW     RAM word index
//  mem_wdata    out  DW     RAM write data
//  mem_rdata    in   DW     RAM read data, valid 1 cycle after mem_en&!mem_we
// BEHAVIOUR
//  - Reset: state IDLE, last_winner=FETCH (loader wins first tie); all outputs 0.
//  - FSM: IDLE -> DECODE -> READ -> RESP -> IDLE (fetch); IDLE -> WRITE -> IDLE (load).
//  - Grants issued only in IDLE; one transaction in flight; no req queued internally.
//  - Tie in IDLE: grant the port that did not win last grant (round-robin); single req wins.
//  - Fetch grant cycle T: addr registered. T+1 DECODE: idx=addr/6, rem=addr%6 registered.
//    T+2 READ: if rem==0 and idx<DEPTH drive mem_en=1, mem_we=0, mem_index=idx.
//    T+3 RESP: fetch_valid=1, fetch_data=mem_rdata, fault=0; earliest next grant T+4.
//  - Fault (rem!=0 or idx>=DEPTH): no mem_en in READ; RESP at T+3 with fault=1, data=0.
//  - Quotient computed on full 32-bit addr; idx>=DEPTH checked before truncation to AW.
//  - Load grant cycle T: T+1 WRITE drives mem_en=1, mem_we=1, mem_index/wdata from regs;
//    earliest next grant T+2. Fetch of same word granted after WRITE returns new data.
//  - fetch_data held stable outside fetch_valid (last value) is not guaranteed; bench
//    checks only when fetch_valid.
//  - rst at any state: return to IDLE next edge, in-flight op dropped, no valid/gnt pulses,
//    an issued write may or may not have landed.
//  - Req deasserted before grant: nothing happens; req after grant is ignored until IDLE.
// STRUCTURE
//  - hatch_pkg: DW, DEPTH, INSN_BYTES=6, state enum (IDLE,DECODE,READ,RESP,WRITE),
//    winner enum (FETCH,LOAD).
//  - Sub-module hatch_div6: 32-bit constant divide by 6, outputs quotient and remainder
//    (combinational; result registered by DECODE stage).
//  - Rest (FSM, round-robin flag, addr/data regs) flat in this module.
// TESTING
//  1 mem[2]=48'hAABBCCDDEEFF, fetch addr 12 -> gnt T, mem_en/idx 2 at T+2, valid T+3 data
//    AABBCCDDEEFF fault 0.
//  2 fetch addr 13 -> no mem_en, valid T+3 fault 1 data 0; addr 1536 -> same fault.
//  3 load_req & fetch_req same cycle after reset -> load_gnt first, fetch_gnt 2 cycles
//    later; repeat tie -> fetch_gnt first.
//  4 load idx 5 data 48'h123456789ABC, then fetch addr 30 -> valid data 123456789ABC.
//  5 rst asserted during READ -> no fetch_valid, IDLE next cycle, next fetch normal.
//  6 fetch_req held continuously at addr 0,6,12 -> grants every 4 cycles, data in order.

Source files
------------

// File: rtl/hatch_pkg.sv
// Shared constants and enums for the instruction-memory arbiter.
package hatch_pkg;

    localparam int unsigned DW         = 48;
    localparam int unsigned DEPTH      = 256;
    localparam int unsigned AW         = 8;
    localparam int unsigned INSN_BYTES = 6;
    localparam int unsigned ADDR_W     = 32;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        READ,
        RESP,
        WRITE
    } state_t;

    typedef enum logic {
        FETCH,
        LOAD
    } winner_t;

endpackage

// File: rtl/hatch_div6.sv
// Combinational 32-bit divide by the 6-byte instruction size.
module hatch_div6
    import hatch_pkg::*;
(
    input  logic [ADDR_W-1:0] dividend,
    output logic [ADDR_W-1:0] quotient,
    output logic [2:0]        remainder
);

    // ceil(2^34 / 6); exact quotient for every 32-bit unsigned dividend
    localparam logic [ADDR_W-1:0] RECIP = 32'hAAAA_AAAB;

    // Reciprocal multiply, then recover the remainder from the quotient
    always_comb begin
        quotient  = 32'((64'(dividend) * 64'(RECIP)) >> 34);
        remainder = 3'(dividend - quotient * 32'(INSN_BYTES));
    end

endmodule

// File: rtl/hatch_imem_arbiter.sv
// Arbitrates CPU fetches and loader writes onto the single-port instruction RAM.
module hatch_imem_arbiter
    import hatch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_valid,
    output logic [DW-1:0]     fetch_data,
    output logic              fetch_fault,
    input  logic              load_req,
    input  logic [AW-1:0]     load_index,
    input  logic [DW-1:0]     load_data,
    output logic              load_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_index,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata
);

    state_t              state_q, state_d;
    winner_t             winner_q, winner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                bad_q, bad_d;
    logic                en_d, we_d, valid_d, fault_d;
    logic [AW-1:0]       index_d;
    logic [DW-1:0]       wdata_d;
    logic                word_ok;
    logic [ADDR_W-1:0]   quo;
    logic [2:0]          rem;

    hatch_div6 u_div6 (
        .dividend  (addr_q),
        .quotient  (quo),
        .remainder (rem)
    );

    // RAM returns data a cycle after the read enable, so the response word is passed through
    assign fetch_data = (fetch_valid && !fetch_fault) ? mem_rdata : '0;

    // State, round-robin flag, captured request and RAM/response output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            winner_q    <= FETCH;
            addr_q      <= '0;
            bad_q       <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_index   <= '0;
            mem_wdata   <= '0;
            fetch_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            addr_q      <= addr_d;
            bad_q       <= bad_d;
            mem_en      <= en_d;
            mem_we      <= we_d;
            mem_index   <= index_d;
            mem_wdata   <= wdata_d;
            fetch_valid <= valid_d;
            fetch_fault <= fault_d;
        end
    end

    // Next-state, grant decisions and next values of the registered outputs
    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        addr_d    = addr_q;
        bad_d     = bad_q;
        en_d      = 1'b0;
        we_d      = 1'b0;
        index_d   = mem_index;
        wdata_d   = mem_wdata;
        valid_d   = 1'b0;
        fault_d   = 1'b0;
        fetch_gnt = 1'b0;
        load_gnt  = 1'b0;
        word_ok   = 1'b0;

        case (state_q)
            IDLE: begin
                // no grants while reset is held; on a tie the previous loser wins
                if (!rst) begin
                    if (load_req && (!fetch_req || winner_q == FETCH)) begin
                        load_gnt = 1'b1;
                        winner_d = LOAD;
                        en_d     = 1'b1;
                        we_d     = 1'b1;
                        index_d  = load_index;
                        wdata_d  = load_data;
                        state_d  = WRITE;
                    end else if (fetch_req) begin
                        fetch_gnt = 1'b1;
                        winner_d  = FETCH;
                        addr_d    = fetch_addr;
                        state_d   = DECODE;
                    end
                end
            end
            DECODE: begin
                // range check on the full quotient, before narrowing to the index width
                word_ok = (rem == 3'd0) && (quo < 32'(DEPTH));
                bad_d   = !word_ok;
                en_d    = word_ok;
                if (word_ok) begin
                    index_d = AW'(quo);
                end
                state_d = READ;
            end
            READ: begin
                valid_d = 1'b1;
                fault_d = bad_q;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule
